// File: rtl/computer_mc.sv
// computer_mc: multi-cycle two-register accumulator computer.
// FETCH pulls one instruction over a req/valid handshake of any latency,
// EXEC retires it in one cycle, HALT freezes the core until reset.
module computer_mc #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int IW     = DATA_W + 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [IW-1:0]     imem_rdata,
    input  logic              imem_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b,
    output logic [DATA_W-1:0] alu_out,
    output logic [3:0]        flags,
    output logic              halted,
    output logic              illegal
);
    localparam int MSB = DATA_W - 1;

    typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_HALT = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]        flags_q, flags_d;     // {Z,N,C,V}
    logic [IW-1:0]     ir_q, ir_d;
    logic              illegal_q, illegal_d;

    logic [6:0]               opcode;
    logic [DATA_W-1:0]        k;
    logic [ADDR_W+DATA_W-1:0] k_ext;
    logic [ADDR_W-1:0]        jmp_tgt;
    logic                     unused_bits;

    logic [DATA_W-1:0] x, y, alu_res;
    logic [DATA_W:0]   sum_w, diff_w;
    logic [3:0]        alu_flags;
    logic              is_add, is_sub, is_log;

    assign opcode  = ir_q[IW-1:IW-7];
    assign k       = ir_q[DATA_W-1:0];
    // Zero-extend then cut to ADDR_W so the jump target works for any width mix.
    assign k_ext   = {{ADDR_W{1'b0}}, k};
    assign jmp_tgt = k_ext[ADDR_W-1:0];
    // Reserved instruction bits are architecturally ignored.
    assign unused_bits = ^{ir_q[IW-8:DATA_W], k_ext[ADDR_W+DATA_W-1:ADDR_W]};

    // Request is combinational on run so a fetch can complete in the cycle it starts;
    // gating with rst_n keeps it low for the whole reset.
    assign imem_req  = rst_n && run && (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign reg_a     = a_q;
    assign reg_b     = b_q;
    assign flags     = flags_q;
    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;
    assign alu_out   = alu_res;

    // ALU: operand select, result and flag candidates for the instruction in IR.
    always_comb begin
        x       = a_q;
        y       = b_q;
        is_add  = 1'b0;
        is_sub  = 1'b0;
        is_log  = 1'b0;
        alu_res = a_q;
        case (opcode)
            7'd0:        alu_res = b_q;
            7'd1:        alu_res = a_q;
            7'd2, 7'd3:  alu_res = k;
            7'd4, 7'd5:  is_add = 1'b1;
            7'd6:        begin y = k; is_add = 1'b1; end
            7'd7:        begin x = b_q; y = k; is_add = 1'b1; end
            7'd8, 7'd13: is_sub = 1'b1;
            7'd9:        begin y = k; is_sub = 1'b1; end
            7'd10:       begin alu_res = a_q & b_q; is_log = 1'b1; end
            7'd11:       begin alu_res = a_q | b_q; is_log = 1'b1; end
            7'd12:       begin alu_res = a_q ^ b_q; is_log = 1'b1; end
            default:     alu_res = a_q;
        endcase
        sum_w  = {1'b0, x} + {1'b0, y};
        diff_w = {1'b0, x} - {1'b0, y};
        if (is_add) alu_res = sum_w[MSB:0];
        if (is_sub) alu_res = diff_w[MSB:0];
        alu_flags = flags_q;
        if (is_add)
            alu_flags = {alu_res == '0, alu_res[MSB], sum_w[DATA_W],
                         (x[MSB] == y[MSB]) && (alu_res[MSB] != x[MSB])};
        else if (is_sub)
            alu_flags = {alu_res == '0, alu_res[MSB], diff_w[DATA_W],
                         (x[MSB] != y[MSB]) && (alu_res[MSB] != x[MSB])};
        else if (is_log)
            alu_flags = {alu_res == '0, alu_res[MSB], 2'b00};
    end

    // Next-state: fetch handshake, single-cycle execute, halt freeze.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        a_d       = a_q;
        b_d       = b_q;
        flags_d   = flags_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH: begin
                if (imem_req && imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_FETCH;
                flags_d = alu_flags;
                case (opcode)
                    7'd0, 7'd2, 7'd4, 7'd6, 7'd8, 7'd9,
                    7'd10, 7'd11, 7'd12:        a_d = alu_res;
                    7'd1, 7'd3, 7'd5, 7'd7:     b_d = alu_res;
                    7'd13, 7'd18:               ;
                    7'd14:                      pc_d = jmp_tgt;
                    7'd15: if (flags_q[3])      pc_d = jmp_tgt;
                    7'd16: if (!flags_q[3])     pc_d = jmp_tgt;
                    7'd17: if (flags_q[1])      pc_d = jmp_tgt;
                    7'd127: begin
                        pc_d    = pc_q;
                        state_d = S_HALT;
                    end
                    default:                    illegal_d = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    // Architectural state and FSM register; async reset drops any pending fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            flags_q   <= '0;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            flags_q   <= flags_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end
endmodule
